// File: rtl/alu_pkg.sv
// Shared types, packet/error constants and the reference CRC4 for the serial ALU receive path.
package alu_pkg;

  typedef enum logic {
    OK    = 1'b0,
    ERROR = 1'b1
  } status_t;

  typedef enum logic [2:0] {
    AND = 3'b000,
    OR  = 3'b001,
    ADD = 3'b100,
    SUB = 3'b101
  } alu_op_t;

  typedef enum logic [2:0] {
    RX_IDLE    = 3'd0,
    RX_TYPE    = 3'd1,
    RX_PAYLOAD = 3'd2,
    RX_STOP    = 3'd3,
    RX_EMIT    = 3'd4
  } rx_state_t;

  localparam logic PKT_DATA = 1'b0;
  localparam logic PKT_CMD  = 1'b1;

  localparam int ERR_OP_BIT   = 0;
  localparam int ERR_CRC_BIT  = 1;
  localparam int ERR_DATA_BIT = 2;

  // CRC4, poly x^4+x+1, init 0, MSB first over {B, A, 1'b1, op}.
  function automatic logic [3:0] crc4_d68(input logic [67:0] d);
    logic [3:0] c;
    logic       fb;
    c = '0;
    for (int i = 67; i >= 0; i--) begin
      fb = c[3] ^ d[i];
      c  = {c[2], c[1], c[0] ^ fb, fb};
    end
    return c;
  endfunction

endpackage

// File: rtl/alu_rx_crc4.sv
// Bit-serial CRC4 LFSR (x^4+x+1, init 0, MSB first); clr has priority over en.
module alu_rx_crc4 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       en,
  input  logic       din,
  output logic [3:0] crc_o
);

  logic [3:0] crc_q, crc_d;
  logic       fb;

  always_comb begin
    fb    = crc_q[3] ^ din;
    crc_d = crc_q;
    if (clr) begin
      crc_d = '0;
    end else if (en) begin
      crc_d = {crc_q[2], crc_q[1], crc_q[0] ^ fb, fb};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      crc_q <= '0;
    end else begin
      crc_q <= crc_d;
    end
  end

  assign crc_o = crc_q;

endmodule

// File: rtl/alu_serial_rx.sv
// Serial ALU input deserializer and frame checker; optional idle timeout under ALU_SERIAL_RX_TIMEOUT_EN.
// Handshake: out_valid holds with stable outputs until a cycle with out_valid & out_ready.
module alu_serial_rx
  import alu_pkg::*;
#(
  parameter int unsigned DATA_PKTS = 8
`ifdef ALU_SERIAL_RX_TIMEOUT_EN
  , parameter int unsigned TIMEOUT_CYCLES = 64
`endif
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        sin,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_status,
  output logic [31:0] out_a,
  output logic [31:0] out_b,
  output logic [2:0]  out_op,
  output logic [2:0]  out_err_flags,
  output logic        overrun
);

  localparam logic [3:0] DATA_PKTS_L = 4'(DATA_PKTS);

  rx_state_t   state_q, state_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [3:0]  pkt_cnt_q, pkt_cnt_d;
  logic        type_q, type_d;
  logic [7:0]  pay_q, pay_d;
  logic [63:0] shreg_q, shreg_d;
  logic        stop_err_q, stop_err_d;
  logic [2:0]  pend_op_q, pend_op_d;
  logic [2:0]  pend_err_q, pend_err_d;
  logic        valid_q, valid_d;
  logic [31:0] a_q, a_d, b_q, b_d;
  logic [2:0]  op_q, op_d, err_q, err_d;
  logic        overrun_q, overrun_d;
  logic        crc_clr, crc_en, crc_din;
  logic [3:0]  crc_val;

`ifdef ALU_SERIAL_RX_TIMEOUT_EN
  localparam int IDLE_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [IDLE_W-1:0] idle_cnt_q, idle_cnt_d;
`endif

  alu_rx_crc4 u_crc (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (crc_clr),
    .en    (crc_en),
    .din   (crc_din),
    .crc_o (crc_val)
  );

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    pkt_cnt_d  = pkt_cnt_q;
    type_d     = type_q;
    pay_d      = pay_q;
    shreg_d    = shreg_q;
    stop_err_d = stop_err_q;
    pend_op_d  = pend_op_q;
    pend_err_d = pend_err_q;
    valid_d    = valid_q & ~out_ready;
    a_d        = a_q;
    b_d        = b_q;
    op_d       = op_q;
    err_d      = err_q;
    overrun_d  = overrun_q;
    crc_clr    = 1'b0;
    crc_en     = 1'b0;
    crc_din    = sin;
`ifdef ALU_SERIAL_RX_TIMEOUT_EN
    idle_cnt_d = '0;
`endif

    unique case (state_q)
      RX_IDLE: begin
        if (!sin) begin
          state_d = RX_TYPE;
        end
`ifdef ALU_SERIAL_RX_TIMEOUT_EN
        else if (pkt_cnt_q != 4'd0) begin
          if (idle_cnt_q == IDLE_W'(TIMEOUT_CYCLES - 1)) begin
            pkt_cnt_d  = '0;
            shreg_d    = '0;
            stop_err_d = 1'b0;
            crc_clr    = 1'b1;
          end else begin
            idle_cnt_d = idle_cnt_q + 1'b1;
          end
        end
`endif
      end
      RX_TYPE: begin
        type_d    = sin;
        bit_cnt_d = 3'd7;
        state_d   = RX_PAYLOAD;
      end
      RX_PAYLOAD: begin
        pay_d     = {pay_q[6:0], sin};
        bit_cnt_d = bit_cnt_q - 3'd1;
        // Cmd payload: leading 0 is replaced by the constant 1, op bits follow, crc bits are not hashed.
        if (type_q == PKT_DATA) begin
          crc_en = 1'b1;
        end else begin
          crc_en  = (bit_cnt_q >= 3'd4);
          crc_din = (bit_cnt_q == 3'd7) ? 1'b1 : sin;
        end
        if (bit_cnt_q == 3'd0) begin
          state_d = RX_STOP;
        end
      end
      RX_STOP: begin
        if (type_q == PKT_DATA) begin
          shreg_d = {shreg_q[55:0], pay_q};
          if (pkt_cnt_q != 4'hF) begin
            pkt_cnt_d = pkt_cnt_q + 4'd1;
          end
          if (!sin) begin
            stop_err_d = 1'b1;
          end
          state_d = RX_IDLE;
        end else begin
          pend_op_d  = pay_q[6:4];
          pend_err_d = '0;
          if (pkt_cnt_q != DATA_PKTS_L || stop_err_q || !sin) begin
            pend_err_d[ERR_DATA_BIT] = 1'b1;
          end else begin
            pend_err_d[ERR_OP_BIT]  = !(pay_q[6:4] inside {AND, OR, ADD, SUB});
            pend_err_d[ERR_CRC_BIT] = (crc_val != pay_q[3:0]);
          end
          state_d = RX_EMIT;
        end
      end
      RX_EMIT: begin
        if (!valid_q || out_ready) begin
          valid_d = 1'b1;
          a_d     = shreg_q[31:0];
          b_d     = shreg_q[63:32];
          op_d    = pend_op_q;
          err_d   = pend_err_q;
        end else begin
          overrun_d = 1'b1;
        end
        pkt_cnt_d  = '0;
        stop_err_d = 1'b0;
        crc_clr    = 1'b1;
        state_d    = RX_IDLE;
      end
      default: state_d = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= RX_IDLE;
      bit_cnt_q  <= '0;
      pkt_cnt_q  <= '0;
      type_q     <= 1'b0;
      pay_q      <= '0;
      shreg_q    <= '0;
      stop_err_q <= 1'b0;
      pend_op_q  <= '0;
      pend_err_q <= '0;
      valid_q    <= 1'b0;
      a_q        <= '0;
      b_q        <= '0;
      op_q       <= '0;
      err_q      <= '0;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      pkt_cnt_q  <= pkt_cnt_d;
      type_q     <= type_d;
      pay_q      <= pay_d;
      shreg_q    <= shreg_d;
      stop_err_q <= stop_err_d;
      pend_op_q  <= pend_op_d;
      pend_err_q <= pend_err_d;
      valid_q    <= valid_d;
      a_q        <= a_d;
      b_q        <= b_d;
      op_q       <= op_d;
      err_q      <= err_d;
      overrun_q  <= overrun_d;
    end
  end

`ifdef ALU_SERIAL_RX_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idle_cnt_q <= '0;
    end else begin
      idle_cnt_q <= idle_cnt_d;
    end
  end
`endif

  assign out_valid     = valid_q;
  assign out_a         = a_q;
  assign out_b         = b_q;
  assign out_op        = op_q;
  assign out_err_flags = err_q;
  assign out_status    = (|err_q) ? ERROR : OK;
  assign overrun       = overrun_q;

endmodule

// File: tb/tb_alu_serial_rx.sv
// Bench for alu_serial_rx: serial driver tasks, expected-request queue with a decoupled monitor.
module tb_alu_serial_rx;
  import alu_pkg::*;

  localparam int TIMEOUT_CYCLES = 64;

  logic        clk;
  logic        rst_n;
  logic        sin;
  logic        out_valid;
  logic        out_ready;
  logic        out_status;
  logic [31:0] out_a;
  logic [31:0] out_b;
  logic [2:0]  out_op;
  logic [2:0]  out_err_flags;
  logic        overrun;

  int n_tests  = 0;
  int n_fail   = 0;
  int n_pushed = 0;
  int n_acc    = 0;

  logic [71:0] exp_q[$];
  logic [71:0] msk_q[$];

  localparam logic [71:0] MSK_ALL  = {72{1'b1}};
  localparam logic [71:0] MSK_NOAB = {8'hFF, 64'h0};

  alu_serial_rx dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .sin           (sin),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_status    (out_status),
    .out_a         (out_a),
    .out_b         (out_b),
    .out_op        (out_op),
    .out_err_flags (out_err_flags),
    .overrun       (overrun)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached, pending=%0d", exp_q.size());
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [71:0] mk_exp(input logic st, input logic [2:0] err,
                                         input logic [2:0] op, input logic [31:0] a,
                                         input logic [31:0] b);
    return {1'b0, st, err, op, a, b};
  endfunction

  // driver tasks
  task automatic send_bit(input logic b);
    @(negedge clk);
    sin = b;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) send_bit(1'b1);
  endtask

  task automatic send_pkt(input logic typ, input logic [7:0] pay, input logic stop);
    send_bit(1'b0);
    send_bit(typ);
    for (int i = 7; i >= 0; i--) send_bit(pay[i]);
    send_bit(stop);
  endtask

  task automatic send_txn(input logic [31:0] b, input logic [31:0] a, input logic [2:0] op,
                          input logic [3:0] crc_x, input int n_data, input int bad_stop);
    logic [63:0] ba;
    logic [3:0]  crc;
    ba  = {b, a};
    crc = crc4_d68({b, a, 1'b1, op}) ^ crc_x;
    for (int i = 0; i < n_data; i++) send_pkt(PKT_DATA, ba[63-8*i -: 8], (i + 1) != bad_stop);
    send_pkt(PKT_CMD, {1'b0, op, crc}, 1'b1);
  endtask

  task automatic push(input logic [71:0] e, input logic [71:0] m);
    exp_q.push_back(e);
    msk_q.push_back(m);
    n_pushed++;
  endtask

  task automatic wait_drain(input int max_cycles);
    int c;
    c = 0;
    while (exp_q.size() != 0 && c < max_cycles) begin
      @(negedge clk);
      c++;
    end
    if (exp_q.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain_timeout: %0d requests still pending, expected 0", exp_q.size());
      exp_q.delete();
      msk_q.delete();
    end
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    logic [71:0] act, e, m;
    if (rst_n && out_valid && out_ready) begin
      n_acc++;
      act = {1'b0, out_status, out_err_flags, out_op, out_a, out_b};
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_req: got %h expected no request", act);
      end else begin
        e = exp_q.pop_front();
        m = msk_q.pop_front();
        chk("request", act & m, e & m);
      end
    end
  end

  initial begin
    rst_n     = 1'b0;
    sin       = 1'b1;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_outputs", {65'h0, out_valid, out_status, out_err_flags, out_op, overrun} | {8'h0, out_a, out_b}, 72'h0);
    rst_n = 1'b1;
    idle(2);

    chk("crc_ref_add_b2_a1", {68'h0, crc4_d68({32'h2, 32'h1, 1'b1, 3'b100})}, 72'hC);

    // valid ADD, with latency check
    push(mk_exp(1'b0, 3'b000, 3'b100, 32'h1, 32'h2), MSK_ALL);
    send_txn(32'h2, 32'h1, ADD, 4'h0, 8, 0);
    @(negedge clk);
    chk("latency_emit_cycle", {71'h0, out_valid}, 72'h0);
    @(negedge clk);
    chk("latency_valid_cycle", {71'h0, out_valid}, 72'h1);
    idle(2);
    wait_drain(50);

    // corrupted crc
    push(mk_exp(1'b1, 3'b010, 3'b100, 32'h1, 32'h2), MSK_ALL);
    send_txn(32'h2, 32'h1, ADD, 4'h1, 8, 0);
    idle(2);
    wait_drain(50);

    // only 7 data packets, then a full valid OR
    push(mk_exp(1'b1, 3'b100, 3'b000, 32'h0, 32'h0), MSK_NOAB);
    send_txn(32'hAABBCCDD, 32'h11223344, AND, 4'h0, 7, 0);
    idle(2);
    wait_drain(50);
    push(mk_exp(1'b0, 3'b000, 3'b001, 32'h0, 32'hFFFFFFFF), MSK_ALL);
    send_txn(32'hFFFFFFFF, 32'h0, OR, 4'h0, 8, 0);
    idle(2);
    wait_drain(50);

    // illegal op, good crc; then illegal op with bad crc
    push(mk_exp(1'b1, 3'b001, 3'b010, 32'h9ABCDEF0, 32'h12345678), MSK_ALL);
    send_txn(32'h12345678, 32'h9ABCDEF0, 3'b010, 4'h0, 8, 0);
    idle(2);
    wait_drain(50);
    push(mk_exp(1'b1, 3'b011, 3'b011, 32'h0000_00A5, 32'h5A00_0000), MSK_ALL);
    send_txn(32'h5A00_0000, 32'h0000_00A5, 3'b011, 4'h8, 8, 0);
    idle(2);
    wait_drain(50);

    // bad stop bit on packet 3 only marks data error
    push(mk_exp(1'b1, 3'b100, 3'b101, 32'h7, 32'h5), MSK_ALL);
    send_txn(32'h5, 32'h7, SUB, 4'h0, 8, 3);
    idle(2);
    wait_drain(50);
    chk("overrun_clear_before", {71'h0, overrun}, 72'h0);

    // back-to-back with consumer stalled
    out_ready = 1'b0;
    push(mk_exp(1'b0, 3'b000, 3'b101, 32'h3, 32'h10), MSK_ALL);
    send_txn(32'h10, 32'h3, SUB, 4'h0, 8, 0);
    idle(2);
    send_txn(32'h1, 32'h1, AND, 4'h0, 8, 0);
    idle(3);
    chk("overrun_set", {71'h0, overrun}, 72'h1);
    chk("valid_held", {71'h0, out_valid}, 72'h1);
    @(posedge clk);
    #1 out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("valid_falls_after_accept", {71'h0, out_valid}, 72'h0);
    chk("overrun_sticky", {71'h0, overrun}, 72'h1);
    wait_drain(50);

    // reset during packet 5
    for (int i = 0; i < 4; i++) send_pkt(PKT_DATA, 8'h3C, 1'b1);
    send_bit(1'b0);
    send_bit(PKT_DATA);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("reset_mid_packet", {65'h0, out_valid, out_status, out_err_flags, out_op, overrun} | {8'h0, out_a, out_b}, 72'h0);
    @(negedge clk);
    sin   = 1'b1;
    rst_n = 1'b1;
    idle(2);
    push(mk_exp(1'b0, 3'b000, 3'b100, 32'hCAFE0001, 32'h0BADF00D), MSK_ALL);
    send_txn(32'h0BADF00D, 32'hCAFE0001, ADD, 4'h0, 8, 0);
    idle(2);
    wait_drain(50);

`ifdef ALU_SERIAL_RX_TIMEOUT_EN
    for (int i = 0; i < 3; i++) send_pkt(PKT_DATA, 8'h77, 1'b1);
    idle(TIMEOUT_CYCLES);
    push(mk_exp(1'b0, 3'b000, 3'b100, 32'h00000011, 32'h00000022), MSK_ALL);
    send_txn(32'h00000022, 32'h00000011, ADD, 4'h0, 8, 0);
    idle(2);
    wait_drain(50);
`endif

    idle(5);
    chk("queue_empty", {40'h0, 32'(exp_q.size())}, 72'h0);
    chk("accept_count", {40'h0, 32'(n_acc)}, {40'h0, 32'(n_pushed)});

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_serial_rx.md
Name: alu_serial_rx

Overview:
- Input deserializer and frame checker for the serial ALU.
- Samples the single-bit `sin` line, assembles operand bytes and the command packet, and checks framing, op code and CRC4.
- Presents one parallel request (A, B, op, status, error flags) per transaction to the ALU core through a valid/ready handshake.

Parameters:
- DATA_PKTS, 8, number of data packets per transaction (B bytes, then A bytes).
- TIMEOUT_CYCLES, 64, idle cycles between packets before a partial transaction is discarded (used only with the optional feature).

Ports:
- clk  in  1  system clock; all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- sin  in  1  serial input; idle high
- out_valid  out  1  request available
- out_ready  in  1  consumer accepts the request
- out_status  out  1  0=OK, 1=ERROR (status_t)
- out_a  out  32  operand A
- out_b  out  32  operand B
- out_op  out  3  operation code (alu_op_t)
- out_err_flags  out  3  {ERR_DATA, ERR_CRC, ERR_OP}
- overrun  out  1  sticky: a completed request was dropped

Behaviour:
- Packet format: 11 bits, sampled one per clk. Fields in order:
  - start = 0
  - type (0 = data, 1 = cmd)
  - 8 payload bits, MSB first
  - stop = 1
- Transaction order:
  - Data packets 1-4: B[31:24] down to B[7:0].
  - Data packets 5-8: A[31:24] down to A[7:0].
  - Then one cmd packet with payload {1'b0, op[2:0], crc4[3:0]}.
- FSM states:
  - IDLE: wait for sin = 0.
  - TYPE: capture type bit.
  - PAYLOAD: 8 bits; 3-bit bit counter.
  - STOP: check stop bit.
  - EMIT: load output registers.
- Bit counter: counts 7 down to 0 in PAYLOAD. Packet counter: 4 bits, saturating at 15.
- Data packet completion: payload is shifted into a 64-bit {B, A} register and the packet counter increments.
- Cmd packet completion: error flags are evaluated, then FSM enters EMIT. Priority:
  1. ERR_DATA if packet count != DATA_PKTS, or any stop bit in the transaction was 0. Only ERR_DATA is set.
  2. Otherwise ERR_OP if op is not one of AND=000, OR=001, ADD=100, SUB=101.
  3. Otherwise ERR_CRC if the received crc4 != CRC4 (poly x^4+x+1, init 0) over the 68 bits {B, A, 1'b1, op}, MSB first. ERR_OP and ERR_CRC may both be set.
- out_status = |out_err_flags.
- EMIT lasts one cycle:
  - If out_valid = 0, or (out_valid and out_ready) in that cycle: load outputs, out_valid = 1 next cycle.
  - Else: drop the new request, set overrun.
  - In all cases, clear the packet counter, stop-error flag and CRC state, then go to IDLE.
- Handshake: out_valid holds, with outputs stable, until the cycle where out_valid and out_ready are both 1. out_valid falls on the next edge unless EMIT reloads it in that same cycle.
- A stop bit of 0 does not abort the transaction; it only marks ERR_DATA.
- A data packet after the packet counter reaches 15 keeps the counter at 15 (ERR_DATA is then guaranteed).
- Reset: applies at any time, mid-packet included.
  - FSM returns to IDLE; all counters and the shift register clear.
  - out_valid = 0, out_status = 0, out_a = out_b = 0, out_op = 0, out_err_flags = 0, overrun = 0.
- Latency: out_valid rises 2 clk after the cmd stop bit is sampled (STOP→EMIT, EMIT→register).

Optional Feature:
- Macro: ALU_SERIAL_RX_TIMEOUT_EN.
- Defined:
  - An idle counter runs in IDLE while the packet count is nonzero.
  - Reaching TIMEOUT_CYCLES clears the packet counter, shift register and CRC state silently; no request is emitted.
  - The counter resets on every start bit.
- Undefined: no counter; a partial transaction waits indefinitely for its cmd packet.

Decomposition:
- alu_pkg holds:
  - status_t {OK, ERROR}
  - alu_op_t {AND, OR, ADD, SUB}
  - packet type constants DATA = 0, CMD = 1
  - err-flag bit indices
  - function crc4_d68(68-bit) returning the 4-bit CRC, shared with the bench and BFM
- Sub-module alu_rx_crc4: bit-serial LFSR, init 0, MSB first.
  - Inputs: clk, rst_n, clr, en, din.
  - Fed with payload bits of data packets, then the constant 1, then op bits, in the cycles they arrive.
  - Its value is compared with the received crc4 in STOP. It must match crc4_d68.

Test Plan:
- B=32'h00000002, A=32'h00000001, op=ADD, correct crc4 → out_valid; out_status=0, out_a=1, out_b=2, out_op=100, err=000.
- Same transaction, crc4 XOR 4'h1 → out_status=1, err=010, out_a and out_b still hold the received values.
- Only 7 data packets then cmd (op=AND) → err=100; next full valid transaction (B=FFFFFFFF, A=0, OR) → OK.
- op=3'b010 with CRC computed over it → err=001.
- Back-to-back valid transactions with out_ready=0 throughout → first request held unchanged, overrun=1 after second cmd; out_ready=1 → out_valid falls next cycle.
- rst_n pulsed low during packet 5 → all outputs 0 immediately; following full ADD transaction → OK.
- With ALU_SERIAL_RX_TIMEOUT_EN: 3 data packets, idle TIMEOUT_CYCLES, then a full valid transaction → single OK request, err=000.
